// File: rtl/fibo_pkg.sv
// Shared types and constants for the Fibonacci stream generator and checker.
// Holds the FSM state encoding, default widths and history reset tags.
package fibo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    HUNT,
    LOCKED
  } fibo_state_t;

  localparam int FIBO_W     = 8;
  localparam int FIBO_CNT_W = 16;

  // History contents after reset; the generator restarts from the same tags.
  localparam int FIBO_RST_PREV = 0;
  localparam int FIBO_RST_CUR  = 0;

endpackage

// File: rtl/fibo_next.sv
// Next Fibonacci term: (a + b) mod 2^W, purely combinational.
// Zero latency; no flow control, output follows inputs.
module fibo_next
  import fibo_pkg::*;
#(
  parameter int W = FIBO_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  // Result is W bits wide, so the carry out falls away.
  assign sum = a + b;

endmodule

// File: rtl/fibo_stream_checker.sv
// Receive-side Fibonacci recurrence checker: locks after LOCK_N matches, counts locked mismatches.
// Outputs registered one cycle after the accepting edge; accepts a sample every valid cycle, never stalls.
module fibo_stream_checker
  import fibo_pkg::*;
#(
  parameter int W      = FIBO_W,
  parameter int LOCK_N = 4,
  parameter int CNT_W  = FIBO_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count,
  output logic [W-1:0]     exp_data
);

  localparam logic [3:0] LOCK_V = 4'(LOCK_N);

  fibo_state_t  state;
  logic [W-1:0] prev;
  logic [W-1:0] cur;
  logic [W-1:0] want;
  logic [W-1:0] nxt_prev;
  logic [W-1:0] nxt_exp;
  logic [3:0]   run;
  logic [3:0]   run_inc;
  logic         match;

  fibo_next #(.W(W)) u_want (
    .a   (prev),
    .b   (cur),
    .sum (want)
  );

  // The first sample only loads cur; every later one shifts the history.
  assign nxt_prev = (state == IDLE) ? prev : cur;

  fibo_next #(.W(W)) u_exp (
    .a   (nxt_prev),
    .b   (in_data),
    .sum (nxt_exp)
  );

  assign match   = (in_data == want);
  assign run_inc = run + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      prev         <= W'(FIBO_RST_PREV);
      cur          <= W'(FIBO_RST_CUR);
      run          <= 4'd0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
      sample_count <= '0;
      exp_data     <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        sample_count <= sample_count + CNT_W'(1);
        prev         <= nxt_prev;
        cur          <= in_data;
        exp_data     <= nxt_exp;
        case (state)
          IDLE: begin
            state <= PRIME;
          end
          PRIME: begin
            run   <= 4'd0;
            state <= HUNT;
          end
          HUNT: begin
            if (match) begin
              run <= run_inc;
              if (run_inc == LOCK_V) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              run <= 4'd0;
            end
          end
          LOCKED: begin
            if (!match) begin
              err_pulse <= 1'b1;
              if (err_count != '1) err_count <= err_count + CNT_W'(1);
              run    <= 4'd0;
              state  <= HUNT;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fibo_stream_checker.sv
// Scoreboard bench for fibo_stream_checker, plus a narrow-counter instance for saturation.
module tb_fibo_stream_checker;

  localparam int W      = 8;
  localparam int CNT_W  = 16;
  localparam int LOCK_N = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] sample_count;
  logic [W-1:0]     exp_data;

  logic             s_valid;
  logic [W-1:0]     s_data;
  logic             s_locked;
  logic             s_err_pulse;
  logic [3:0]       s_err_count;
  logic [3:0]       s_sample_count;
  logic [W-1:0]     s_exp_data;

  fibo_stream_checker #(.W(W), .LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .sample_count (sample_count),
    .exp_data     (exp_data)
  );

  fibo_stream_checker #(.W(W), .LOCK_N(1), .CNT_W(4)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (s_valid),
    .in_data      (s_data),
    .locked       (s_locked),
    .err_pulse    (s_err_pulse),
    .err_count    (s_err_count),
    .sample_count (s_sample_count),
    .exp_data     (s_exp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] sample_count;
    logic [W-1:0]     exp_data;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int               m_st;
  logic [W-1:0]     m_prev;
  logic [W-1:0]     m_cur;
  int               m_run;
  logic [CNT_W-1:0] m_errc;
  logic [CNT_W-1:0] m_samp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_prev = '0;
    m_cur  = '0;
    m_run  = 0;
    m_errc = '0;
    m_samp = '0;
    last_exp = '0;
  endtask

  task automatic model_accept(input logic [W-1:0] d);
    exp_t         e;
    logic [W-1:0] sum;
    logic         pulse;
    sum   = m_prev + m_cur;
    pulse = 1'b0;
    case (m_st)
      0: begin
        m_cur = d;
        m_st  = 1;
      end
      1: begin
        m_prev = m_cur;
        m_cur  = d;
        m_run  = 0;
        m_st   = 2;
      end
      2: begin
        if (d == sum) begin
          m_run++;
          if (m_run == LOCK_N) m_st = 3;
        end else begin
          m_run = 0;
        end
        m_prev = m_cur;
        m_cur  = d;
      end
      default: begin
        if (d != sum) begin
          pulse = 1'b1;
          if (m_errc != {CNT_W{1'b1}}) m_errc++;
          m_run = 0;
          m_st  = 2;
        end
        m_prev = m_cur;
        m_cur  = d;
      end
    endcase
    m_samp++;
    e.locked       = (m_st == 3);
    e.err_pulse    = pulse;
    e.err_count    = m_errc;
    e.sample_count = m_samp;
    e.exp_data     = m_prev + m_cur;
    sb_q.push_back(e);
  endtask

  task automatic compare_out(input string tag, input exp_t e);
    check_eq({tag, ".locked"},       32'(locked),       32'(e.locked));
    check_eq({tag, ".err_pulse"},    32'(err_pulse),    32'(e.err_pulse));
    check_eq({tag, ".err_count"},    32'(err_count),    32'(e.err_count));
    check_eq({tag, ".sample_count"}, 32'(sample_count), 32'(e.sample_count));
    check_eq({tag, ".exp_data"},     32'(exp_data),     32'(e.exp_data));
  endtask

  task automatic send(input logic [W-1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    model_accept(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      last_exp = sb_q.pop_front();
      compare_out("sample", last_exp);
    end
  endtask

  // Idle cycles: outputs hold and err_pulse stays low.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_eq("gap.err_pulse",    32'(err_pulse),    32'd0);
      check_eq("gap.locked",       32'(locked),       32'(last_exp.locked));
      check_eq("gap.sample_count", 32'(sample_count), 32'(last_exp.sample_count));
      check_eq("gap.exp_data",     32'(exp_data),     32'(last_exp.exp_data));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send_seq6();
    send(8'd0); send(8'd1); send(8'd1); send(8'd2); send(8'd3); send(8'd5);
  endtask

  // Saturation instance: LOCK_N=1, 4-bit counters.
  logic [W-1:0] sp, sc, bad, good;
  logic [3:0]   serr, ssamp;

  task automatic sat_send(input logic [W-1:0] d);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    ssamp   = ssamp + 4'd1;
    check_eq("sat.sample_count", 32'(s_sample_count), 32'(ssamp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] gap_seq [6];
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    s_valid  = 1'b0;
    s_data   = '0;
    model_reset();
    #12;
    check_eq("rst.locked",       32'(locked),       32'd0);
    check_eq("rst.err_pulse",    32'(err_pulse),    32'd0);
    check_eq("rst.err_count",    32'(err_count),    32'd0);
    check_eq("rst.sample_count", 32'(sample_count), 32'd0);
    check_eq("rst.exp_data",     32'(exp_data),     32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back lock
    send_seq6();
    check_eq("b2b.locked",       32'(locked),       32'd1);
    check_eq("b2b.err_count",    32'(err_count),    32'd0);
    check_eq("b2b.sample_count", 32'(sample_count), 32'd6);
    check_eq("b2b.exp_data",     32'(exp_data),     32'd8);

    // Run up to (144,233), then the wrapped term 121
    send(8'd8); send(8'd13); send(8'd21); send(8'd34);
    send(8'd55); send(8'd89); send(8'd144); send(8'd233);
    send(8'd121);
    check_eq("wrap.locked",   32'(locked),   32'd1);
    check_eq("wrap.exp_data", 32'(exp_data), 32'd98);

    // Locked mismatch at (3,5) and re-acquire
    do_reset();
    send_seq6();
    send(8'd9);
    check_eq("mis.err_pulse", 32'(err_pulse), 32'd1);
    check_eq("mis.err_count", 32'(err_count), 32'd1);
    check_eq("mis.locked",    32'(locked),    32'd0);
    check_eq("mis.exp_data",  32'(exp_data),  32'd14);
    gap(1);
    send(8'd14); send(8'd23); send(8'd37);
    check_eq("relock.early", 32'(locked), 32'd0);
    send(8'd60);
    check_eq("relock.locked", 32'(locked), 32'd1);

    // Same stream with random valid gaps
    do_reset();
    gap_seq = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5};
    foreach (gap_seq[i]) begin
      send(gap_seq[i]);
      gap(int'($urandom_range(1, 3)));
    end
    check_eq("gaps.locked",       32'(locked),       32'd1);
    check_eq("gaps.err_count",    32'(err_count),    32'd0);
    check_eq("gaps.sample_count", 32'(sample_count), 32'd6);
    check_eq("gaps.exp_data",     32'(exp_data),     32'd8);

    // Asynchronous reset mid-cycle while a sample is offered
    @(negedge clk);
    #2;
    in_valid = 1'b1;
    in_data  = 8'd8;
    rst      = 1'b1;
    #1;
    check_eq("arst.locked",       32'(locked),       32'd0);
    check_eq("arst.err_pulse",    32'(err_pulse),    32'd0);
    check_eq("arst.err_count",    32'(err_count),    32'd0);
    check_eq("arst.sample_count", 32'(sample_count), 32'd0);
    check_eq("arst.exp_data",     32'(exp_data),     32'd0);
    @(posedge clk);
    #1;
    check_eq("arst.dropped", 32'(sample_count), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    model_reset();
    send(8'd8); send(8'd13);
    send(8'd21); send(8'd34); send(8'd55); send(8'd89);
    check_eq("arst.relock", 32'(locked), 32'd1);

    // Saturation and LOCK_N=1 on the narrow instance
    ssamp = 4'd0;
    serr  = 4'd0;
    sat_send(8'd0); sat_send(8'd1); sat_send(8'd1);
    check_eq("lock1.locked", 32'(s_locked), 32'd1);
    sp = 8'd1;
    sc = 8'd1;
    for (int i = 0; i < 16; i++) begin
      bad = sp + sc + 8'd1;
      sat_send(bad);
      serr = (serr == 4'hF) ? 4'hF : serr + 4'd1;
      check_eq("sat.err_pulse", 32'(s_err_pulse), 32'd1);
      check_eq("sat.err_count", 32'(s_err_count), 32'(serr));
      check_eq("sat.unlocked",  32'(s_locked),    32'd0);
      sp   = sc;
      sc   = bad;
      good = sp + sc;
      sat_send(good);
      check_eq("sat.pulse_drop", 32'(s_err_pulse), 32'd0);
      check_eq("sat.relock",     32'(s_locked),    32'd1);
      sp = sc;
      sc = good;
    end
    check_eq("sat.final", 32'(s_err_count), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fibo_stream_checker.md
# fibo_stream_checker

Receive-side checker for the 8-bit Fibonacci stream produced by the team's pausable Fibonacci generator. The generator emits one value per advancing cycle; this block sits at the consuming end. It samples the stream under a valid strobe and verifies the recurrence x[n] = x[n-1] + x[n-2] mod 2^W. It acquires lock after a run of matches and reports mismatches through an error pulse and a saturating error counter, re-acquiring lock without software intervention.

## Interface
Parameters:
- W, default 8: data width; all arithmetic is mod 2^W.
- LOCK_N, default 4: consecutive matching samples required to enter LOCKED; legal range 1..15.
- CNT_W, default 16: width of the error and sample counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  sample strobe; in_data is consumed only in cycles where in_valid=1.
- in_data  in  W  stream value.
- locked  out  1  registered; 1 while in LOCKED.
- err_pulse  out  1  registered; one-cycle pulse for each mismatch detected while LOCKED.
- err_count  out  CNT_W  registered; saturating count of err_pulse events.
- sample_count  out  CNT_W  registered; count of accepted samples, wraps mod 2^CNT_W.
- exp_data  out  W  registered; value expected for the next sample (prev + cur). Meaningful only when the state is HUNT or LOCKED.

## Operation
- History registers: prev and cur, both W bits. Run counter: run, 4 bits.
- States and transitions (all on a cycle with in_valid=1; when in_valid=0, no state changes):
  - IDLE: cur<=in_data; go to PRIME.
  - PRIME: prev<=cur; cur<=in_data; run<=0; go to HUNT.
  - HUNT:
    - Match (in_data == prev+cur mod 2^W): run<=run+1. When run+1 == LOCK_N, go to LOCKED.
    - Mismatch: run<=0; stay in HUNT. No error is counted.
    - History shifts on both match and mismatch.
  - LOCKED:
    - Match: stay.
    - Mismatch: err_pulse<=1; err_count<=err_count+1, saturating at all-ones; run<=0; go to HUNT; history shifts.
- History shift on each accepted sample from HUNT or LOCKED: prev<=cur; cur<=in_data.
- exp_data <= next prev + next cur, truncated to W bits. Carry is discarded (wrap-around).
- sample_count increments on every accepted sample in every state.
- err_pulse is 0 in every cycle that does not detect a locked mismatch, including cycles with in_valid=0.
- Reset values:
  - state=IDLE; prev=cur=0; run=0.
  - locked=0; err_pulse=0; err_count=0; sample_count=0; exp_data=0.
  - Reset mid-stream discards the history. The first sample after reset is treated as a fresh start.

## Timing
- Single clock domain. All outputs are registered.
- Each output reflects a sample one cycle after the edge that accepts it; there is no other pipeline latency.
- Throughput: one sample per cycle. Back-to-back valid cycles and arbitrary valid gaps are both legal; gaps do not affect the result.
- When LOCK_N=1, lock is reached on the first match after PRIME.
- Simultaneous saturation and mismatch: err_pulse still fires and err_count holds at all-ones.
- Asynchronous rst asserted in the same cycle as in_valid: reset wins and the sample is dropped.

## Structure
- Shared package fibo_pkg:
  - state enum {IDLE, PRIME, HUNT, LOCKED};
  - default width constants FIBO_W=8 and FIBO_CNT_W=16;
  - reset tag constants shared with the generator.
- Sub-module fibo_next: combinational W-bit adder returning (a+b) mod 2^W. The generator model reuses it.
- The top contains the FSM, the history registers and the counters.

## Test plan
- Reset, then feed 0,1,1,2,3,5 back-to-back with LOCK_N=4:
  - locked=1 in the cycle after the sample 5;
  - err_count=0; sample_count=6; exp_data=8.
- From locked with history (144,233), feed 121 (377 mod 256):
  - match, locked stays 1;
  - next exp_data=98 (354 mod 256).
- From locked with history (3,5), feed 9:
  - err_pulse=1 for exactly one cycle; err_count=1; locked=0;
  - exp_data=14; four further correct samples 14,23,37,60 restore locked=1.
- Feed 0,1,1,2,3,5 with in_valid low for 1-3 random cycles between samples:
  - results are identical to the back-to-back case;
  - err_pulse never asserts during the gaps.
- Preload err_count to 0xFFFE via repeated mismatches in LOCKED (or force it), then cause two locked mismatches:
  - err_count=0xFFFF after both;
  - err_pulse fires on each.
- Assert rst asynchronously mid-stream after locking:
  - all outputs return to 0 immediately; state is IDLE;
  - the next two samples only prime the history, with no error reported.
